// File: rtl/parking_gate_event_conditioner_if.sv
// Gate-side bundle of the parking-lot event conditioner: raw sensors and lot
// status in, clean counter pulses and queue status out.
interface parking_gate_event_conditioner_if;
    logic       entry_sensor_raw;
    logic       exit_sensor_raw;
    logic       lot_full;
    logic       entry_button;
    logic       exit_button;
    logic [1:0] entry_pending;
    logic [1:0] exit_pending;
    logic       entry_rejected;
    logic       overflow_err;

    modport master (
        output entry_sensor_raw,
        output exit_sensor_raw,
        output lot_full,
        input  entry_button,
        input  exit_button,
        input  entry_pending,
        input  exit_pending,
        input  entry_rejected,
        input  overflow_err
    );

    modport slave (
        input  entry_sensor_raw,
        input  exit_sensor_raw,
        input  lot_full,
        output entry_button,
        output exit_button,
        output entry_pending,
        output exit_pending,
        output entry_rejected,
        output overflow_err
    );
endinterface

// File: rtl/parking_gate_event_conditioner.sv
// Synchronizes and debounces the gate sensors, queues car events and issues
// spaced one-cycle entry/exit pulses to the parking-lot counter.
module parking_gate_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int PEND_MAX        = 3
) (
    input logic                            clk,
    input logic                            reset,
    parking_gate_event_conditioner_if.slave gate
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int GAP_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HOLDOFF_CYCLES - 1);
    localparam logic [1:0]       PEND_SAT = 2'(PEND_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE_IN, ISSUE_OUT, GAP} state_t;

    // Channel index 0 is the entry gate, index 1 the exit gate.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q, stable_q, stable_prev_q, rise;
    logic [CNT_W-1:0] cnt_q [2];

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             last_exit_q, last_exit_d;
    logic [1:0]       entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
    logic             entry_btn_q, entry_btn_d, exit_btn_q, exit_btn_d;
    logic             reject_q, reject_d, ovf_q, ovf_d;
    logic             entry_inc, exit_inc, entry_dec, exit_dec;
    logic             entry_ok, exit_ok;

    assign raw  = {gate.exit_sensor_raw, gate.entry_sensor_raw};
    assign rise = stable_q & ~stable_prev_q;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        stable_q[i] <= sync2_q[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        entry_inc    = rise[0] & ~gate.lot_full;
        exit_inc     = rise[1];
        entry_dec    = (state_q == ISSUE_IN);
        exit_dec     = (state_q == ISSUE_OUT);
        entry_pend_d = entry_pend_q;
        exit_pend_d  = exit_pend_q;
        reject_d     = rise[0] & gate.lot_full;
        ovf_d        = 1'b0;
        if (entry_inc && !entry_dec) begin
            if (entry_pend_q == PEND_SAT) ovf_d = 1'b1;
            else                          entry_pend_d = entry_pend_q + 2'd1;
        end else if (entry_dec && !entry_inc) begin
            entry_pend_d = entry_pend_q - 2'd1;
        end
        if (exit_inc && !exit_dec) begin
            if (exit_pend_q == PEND_SAT) ovf_d = 1'b1;
            else                         exit_pend_d = exit_pend_q + 2'd1;
        end else if (exit_dec && !exit_inc) begin
            exit_pend_d = exit_pend_q - 2'd1;
        end
    end

    // When both queues are eligible the side not served last goes first.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = '0;
        last_exit_d = last_exit_q;
        entry_ok    = (entry_pend_q != 2'd0) && !gate.lot_full;
        exit_ok     = (exit_pend_q != 2'd0);
        case (state_q)
            IDLE: begin
                if (entry_ok && exit_ok) state_d = last_exit_q ? ISSUE_IN : ISSUE_OUT;
                else if (entry_ok)       state_d = ISSUE_IN;
                else if (exit_ok)        state_d = ISSUE_OUT;
            end
            ISSUE_IN: begin
                state_d     = GAP;
                last_exit_d = 1'b0;
            end
            ISSUE_OUT: begin
                state_d     = GAP;
                last_exit_d = 1'b1;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        entry_btn_d = (state_d == ISSUE_IN);
        exit_btn_d  = (state_d == ISSUE_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            last_exit_q  <= 1'b0;
            entry_pend_q <= '0;
            exit_pend_q  <= '0;
            entry_btn_q  <= 1'b0;
            exit_btn_q   <= 1'b0;
            reject_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_exit_q  <= last_exit_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            entry_btn_q  <= entry_btn_d;
            exit_btn_q   <= exit_btn_d;
            reject_q     <= reject_d;
            ovf_q        <= ovf_d;
        end
    end

    assign gate.entry_button   = entry_btn_q;
    assign gate.exit_button    = exit_btn_q;
    assign gate.entry_pending  = entry_pend_q;
    assign gate.exit_pending   = exit_pend_q;
    assign gate.entry_rejected = reject_q;
    assign gate.overflow_err   = ovf_q;
endmodule

// File: tb/tb_parking_gate_event_conditioner.sv
// Directed bench: a fast-holdoff instance for timing/arbitration and a
// long-holdoff instance that keeps the FSM in GAP so the queue can fill.
module tb_parking_gate_event_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;

    int mEntryPulses = 0, mExitPulses = 0, mRejects = 0, mOverflows = 0;
    int mEntryEdge = 0, mExitEdge = 0, mOverlap = 0;
    int sEntryPulses = 0, sOverflows = 0;

    parking_gate_event_conditioner_if mainBus();
    parking_gate_event_conditioner_if slowBus();

    parking_gate_event_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2), .PEND_MAX(3)
    ) dut (
        .clk(clk), .reset(reset), .gate(mainBus)
    );

    parking_gate_event_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(100), .PEND_MAX(3)
    ) dutSlow (
        .clk(clk), .reset(reset), .gate(slowBus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Pulse bookkeeping sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mainBus.entry_button) begin
            mEntryPulses++;
            mEntryEdge = cycleCount;
        end
        if (mainBus.exit_button) begin
            mExitPulses++;
            mExitEdge = cycleCount;
        end
        if (mainBus.entry_button && mainBus.exit_button) mOverlap++;
        if (mainBus.entry_rejected) mRejects++;
        if (mainBus.overflow_err) mOverflows++;
        if (slowBus.entry_button) sEntryPulses++;
        if (slowBus.overflow_err) sOverflows++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit toSlow, input bit entryRaw, input bit exitRaw,
                                 input bit lotFull);
        if (toSlow) begin
            slowBus.entry_sensor_raw = entryRaw;
            slowBus.exit_sensor_raw  = exitRaw;
            slowBus.lot_full         = lotFull;
        end else begin
            mainBus.entry_sensor_raw = entryRaw;
            mainBus.exit_sensor_raw  = exitRaw;
            mainBus.lot_full         = lotFull;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base, e0, x0, r0, o0, expPend;

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        waitCycles(3);
        checkOutput("rst_entry_button", int'(mainBus.entry_button), 0);
        checkOutput("rst_exit_button", int'(mainBus.exit_button), 0);
        checkOutput("rst_entry_pending", int'(mainBus.entry_pending), 0);
        checkOutput("rst_exit_pending", int'(mainBus.exit_pending), 0);
        checkOutput("rst_entry_rejected", int'(mainBus.entry_rejected), 0);
        checkOutput("rst_overflow_err", int'(mainBus.overflow_err), 0);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] single entry latency");
        e0 = mEntryPulses;
        x0 = mExitPulses;
        applyStimulus(0, 1, 0, 0);
        base = cycleCount;
        waitCycles(6);
        checkOutput("t1_pending_edge6", int'(mainBus.entry_pending), 0);
        waitCycles(1);
        checkOutput("t1_pending_edge7", int'(mainBus.entry_pending), 1);
        waitCycles(1);
        checkOutput("t1_button_edge8", int'(mainBus.entry_button), 1);
        waitCycles(1);
        checkOutput("t1_button_edge9", int'(mainBus.entry_button), 0);
        checkOutput("t1_pending_edge9", int'(mainBus.entry_pending), 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        waitCycles(20);
        checkOutput("t1_entry_pulses", mEntryPulses - e0, 1);
        checkOutput("t1_entry_edge", mEntryEdge - base, 8);
        checkOutput("t1_exit_pulses", mExitPulses - x0, 0);

        $display("[TB] short glitch");
        e0 = mEntryPulses;
        r0 = mRejects;
        o0 = mOverflows;
        applyStimulus(0, 1, 0, 0);
        waitCycles(3);
        applyStimulus(0, 0, 0, 0);
        waitCycles(20);
        checkOutput("t2_entry_pulses", mEntryPulses - e0, 0);
        checkOutput("t2_entry_pending", int'(mainBus.entry_pending), 0);
        checkOutput("t2_rejects", mRejects - r0, 0);
        checkOutput("t2_overflows", mOverflows - o0, 0);

        $display("[TB] simultaneous entry and exit");
        e0 = mEntryPulses;
        x0 = mExitPulses;
        applyStimulus(0, 1, 1, 0);
        base = cycleCount;
        waitCycles(10);
        applyStimulus(0, 0, 0, 0);
        waitCycles(20);
        checkOutput("t3_exit_pulses", mExitPulses - x0, 1);
        checkOutput("t3_entry_pulses", mEntryPulses - e0, 1);
        checkOutput("t3_exit_edge", mExitEdge - base, 8);
        checkOutput("t3_entry_edge", mEntryEdge - base, 12);
        checkOutput("t3_entry_pending", int'(mainBus.entry_pending), 0);
        checkOutput("t3_exit_pending", int'(mainBus.exit_pending), 0);
        checkOutput("t3_overlap", mOverlap, 0);

        $display("[TB] lot full");
        e0 = mEntryPulses;
        x0 = mExitPulses;
        r0 = mRejects;
        applyStimulus(0, 1, 0, 1);
        waitCycles(7);
        checkOutput("t4_rejected_edge7", int'(mainBus.entry_rejected), 1);
        checkOutput("t4_pending_edge7", int'(mainBus.entry_pending), 0);
        waitCycles(1);
        checkOutput("t4_rejected_edge8", int'(mainBus.entry_rejected), 0);
        waitCycles(2);
        applyStimulus(0, 0, 0, 1);
        waitCycles(20);
        checkOutput("t4_entry_pulses", mEntryPulses - e0, 0);
        checkOutput("t4_rejects", mRejects - r0, 1);
        applyStimulus(0, 0, 1, 1);
        base = cycleCount;
        waitCycles(8);
        checkOutput("t4_exit_button_edge8", int'(mainBus.exit_button), 1);
        waitCycles(2);
        applyStimulus(0, 0, 0, 1);
        waitCycles(20);
        checkOutput("t4_exit_pulses", mExitPulses - x0, 1);
        checkOutput("t4_exit_edge", mExitEdge - base, 8);
        checkOutput("t4_entry_pending_end", int'(mainBus.entry_pending), 0);
        applyStimulus(0, 0, 0, 0);

        // The first rise is issued, then the long GAP holds the FSM while the queue fills.
        $display("[TB] pending saturation");
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        waitCycles(2);
        e0 = sEntryPulses;
        o0 = sOverflows;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 0, 0);
            waitCycles(7);
            expPend = (k == 0) ? 1 : ((k > 3) ? 3 : k);
            checkOutput($sformatf("t5_pending_rise%0d", k), int'(slowBus.entry_pending), expPend);
            checkOutput($sformatf("t5_overflow_rise%0d", k), int'(slowBus.overflow_err),
                        (k == 4) ? 1 : 0);
            waitCycles(1);
            applyStimulus(1, 0, 0, 0);
            waitCycles(8);
        end
        checkOutput("t5_overflow_cleared", int'(slowBus.overflow_err), 0);
        checkOutput("t5_pending_final", int'(slowBus.entry_pending), 3);
        checkOutput("t5_entry_pulses", sEntryPulses - e0, 1);
        checkOutput("t5_overflows", sOverflows - o0, 1);

        $display("[TB] reset mid-gap");
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        waitCycles(2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 0);
            waitCycles(8);
            applyStimulus(1, 0, 0, 0);
            waitCycles(8);
        end
        checkOutput("t6_pending_queued", int'(slowBus.entry_pending), 2);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("t6_entry_pending", int'(slowBus.entry_pending), 0);
        checkOutput("t6_exit_pending", int'(slowBus.exit_pending), 0);
        checkOutput("t6_entry_button", int'(slowBus.entry_button), 0);
        checkOutput("t6_exit_button", int'(slowBus.exit_button), 0);
        checkOutput("t6_rejected", int'(slowBus.entry_rejected), 0);
        checkOutput("t6_overflow", int'(slowBus.overflow_err), 0);
        reset = 1'b0;
        e0 = sEntryPulses;
        waitCycles(150);
        checkOutput("t6_no_pulses", sEntryPulses - e0, 0);
        checkOutput("t6_pending_after", int'(slowBus.entry_pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
